// File: rtl/module_a_xchg_pkg.sv
// Shared defaults and entry layout for the A-side exchange FIFO.
// Entry layout: {tag, data}, tag field above the data field.
package module_a_xchg_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TAG_W   = 4;
  localparam int unsigned DEF_DEPTH   = 8;
  localparam int unsigned DEF_ENTRY_W = DEF_TAG_W + DEF_DATA_W;

  // Data occupies the low bits of an entry, tag sits directly above it.
  localparam int unsigned DATA_LSB = 0;

  function automatic int unsigned entry_w(input int unsigned tag_w, input int unsigned data_w);
    return tag_w + data_w;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned data_w);
    return DATA_LSB + data_w;
  endfunction

endpackage

// File: rtl/module_a_xchg_ram.sv
// DEPTH x ENTRY_W storage: one synchronous write port, one asynchronous read port, no reset.
module module_a_xchg_ram
  import module_a_xchg_pkg::*;
#(
  parameter int unsigned ENTRY_W = DEF_ENTRY_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [PTR_W-1:0]   waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]   raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/module_a_xchg.sv
// A-side exchange: FWFT FIFO buffering B's words with their A-side tag, plus occupancy.
// Optional running XOR of popped data when MODULE_A_XCHG_CHECKSUM_EN is defined.
module module_a_xchg
  import module_a_xchg_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_from_B,
  input  logic              data_from_B_valid,
  output logic              data_from_B_ready,
  input  logic [TAG_W-1:0]  a_extra_in,
  output logic [DATA_W-1:0] data_to_B,
  output logic              data_to_B_valid,
  input  logic              data_to_B_ready,
  output logic [TAG_W-1:0]  a_extra_out,
  input  logic              flush,
  output logic [CNT_W-1:0]  level
`ifdef MODULE_A_XCHG_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int unsigned ENTRY_W = entry_w(TAG_W, DATA_W);
  localparam int unsigned T_LSB   = tag_lsb(DATA_W);
  localparam int unsigned PTR_W   = $clog2(DEPTH);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   level_q, level_d;
  logic [DATA_W-1:0]  hold_data_q, hold_data_d;
  logic [TAG_W-1:0]   hold_tag_q, hold_tag_d;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic               push;
  logic               pop;

  assign data_from_B_ready = (level_q != CNT_W'(DEPTH)) && !flush;
  assign data_to_B_valid   = (level_q != '0);
  assign push              = data_from_B_valid && data_from_B_ready;
  assign pop               = data_to_B_valid && data_to_B_ready;
  assign level             = level_q;
  assign wr_entry          = {a_extra_in, data_from_B};

  module_a_xchg_ram #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Head is read straight from storage; when empty the last shown head is held.
  assign data_to_B   = data_to_B_valid ? rd_entry[DATA_LSB +: DATA_W] : hold_data_q;
  assign a_extra_out = data_to_B_valid ? rd_entry[T_LSB +: TAG_W]     : hold_tag_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    hold_data_d = data_to_B;
    hold_tag_d  = a_extra_out;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + CNT_W'(1);
        2'b01:   level_d = level_q - CNT_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      hold_data_q <= '0;
      hold_tag_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      hold_data_q <= hold_data_d;
      hold_tag_q  <= hold_tag_d;
    end
  end

`ifdef MODULE_A_XCHG_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Flush wins over a same-cycle pop.
  always_comb begin
    csum_d = csum_q;
    if (flush)    csum_d = '0;
    else if (pop) csum_d = csum_q ^ data_to_B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_module_a_xchg.sv
// Scoreboard bench for module_a_xchg: queue-based reference model, directed plus random traffic.
module tb_module_a_xchg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
  } entry_t;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] data_from_B;
  logic              data_from_B_valid;
  logic              data_from_B_ready;
  logic [TAG_W-1:0]  a_extra_in;
  logic [DATA_W-1:0] data_to_B;
  logic              data_to_B_valid;
  logic              data_to_B_ready;
  logic [TAG_W-1:0]  a_extra_out;
  logic              flush;
  logic [CNT_W-1:0]  level;
`ifdef MODULE_A_XCHG_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  int n_cmp = 0;
  int n_err = 0;

  entry_t            exp_q[$];
  logic [DATA_W-1:0] m_csum = '0;

  module_a_xchg #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .data_from_B       (data_from_B),
    .data_from_B_valid (data_from_B_valid),
    .data_from_B_ready (data_from_B_ready),
    .a_extra_in        (a_extra_in),
    .data_to_B         (data_to_B),
    .data_to_B_valid   (data_to_B_valid),
    .data_to_B_ready   (data_to_B_ready),
    .a_extra_out       (a_extra_out),
    .flush             (flush),
    .level             (level)
`ifdef MODULE_A_XCHG_CHECKSUM_EN
    ,
    .checksum          (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor + reference model: sampled mid-cycle, applies the edge's effect afterwards.
  always @(negedge clk) begin
    entry_t e;
    bit     m_ready;
    if (!rst_n) begin
      exp_q.delete();
      m_csum = '0;
    end else begin
      m_ready = (exp_q.size() != DEPTH) && !flush;
      check("ready", 64'(data_from_B_ready), 64'(m_ready));
      check("valid", 64'(data_to_B_valid), 64'(exp_q.size() != 0));
      check("level", 64'(level), 64'(exp_q.size()));
`ifdef MODULE_A_XCHG_CHECKSUM_EN
      check("checksum", 64'(checksum), 64'(m_csum));
`endif
      if (data_to_B_valid && data_to_B_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_when_empty", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("head_data", 64'(data_to_B), 64'(e.d));
          check("head_tag", 64'(a_extra_out), 64'(e.t));
          m_csum = m_csum ^ e.d;
        end
      end
      if (flush) begin
        exp_q.delete();
        m_csum = '0;
      end else if (data_from_B_valid && m_ready) begin
        e.d = data_from_B;
        e.t = a_extra_in;
        exp_q.push_back(e);
      end
    end
  end

  // Apply inputs for one cycle; entered and left at posedge+1.
  task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                     input bit r, input bit f);
    data_from_B_valid = v;
    data_from_B       = d;
    a_extra_in        = t;
    data_to_B_ready   = r;
    flush             = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic rand_cycles(input int n, input int flush_pct);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 3) != 0, DATA_W'($urandom), TAG_W'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 99) < flush_pct);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_valid"}, 64'(data_to_B_valid), 64'(0));
    check({pfx, "_ready"}, 64'(data_from_B_ready), 64'(1));
    check({pfx, "_level"}, 64'(level), 64'(0));
    check({pfx, "_data"}, 64'(data_to_B), 64'(0));
    check({pfx, "_tag"}, 64'(a_extra_out), 64'(0));
`ifdef MODULE_A_XCHG_CHECKSUM_EN
    check({pfx, "_csum"}, 64'(checksum), 64'(0));
`endif
  endtask

  initial begin
    rst_n             = 1'b0;
    data_from_B_valid = 1'b0;
    data_from_B       = '0;
    a_extra_in        = '0;
    data_to_B_ready   = 1'b0;
    flush             = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    idle();

    // Fill to full, then offer a 9th word that must be refused.
    for (int i = 1; i <= 8; i++) cyc(1'b1, DATA_W'(i), TAG_W'(i - 1), 1'b0, 1'b0);
    check("fill_ready", 64'(data_from_B_ready), 64'(0));
    cyc(1'b1, DATA_W'(9), TAG_W'(8), 1'b0, 1'b0);
    data_from_B_valid = 1'b0;
    check("fill_level", 64'(level), 64'(8));

    // Drain: order checked by the monitor.
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("drain_valid", 64'(data_to_B_valid), 64'(0));
    check("drain_level", 64'(level), 64'(0));

    // Concurrent traffic at level 3.
    for (int i = 0; i < 3; i++) cyc(1'b1, DATA_W'(32'h100 + i), TAG_W'(i), 1'b0, 1'b0);
    for (int i = 3; i < 23; i++) begin
      cyc(1'b1, DATA_W'(32'h100 + i), TAG_W'(i), 1'b1, 1'b0);
      check("conc_level", 64'(level), 64'(3));
    end
    drain();

    // Push into empty: visible next cycle.
    cyc(1'b1, DATA_W'(32'hA5), TAG_W'(5), 1'b1, 1'b0);
    data_from_B_valid = 1'b0;
    check("empty_push_valid", 64'(data_to_B_valid), 64'(1));
    check("empty_push_data", 64'(data_to_B), 64'(32'hA5));
    check("empty_push_tag", 64'(a_extra_out), 64'(5));
    drain();

    // Flush at level 5 with a push offered during the flush.
    for (int i = 0; i < 5; i++) cyc(1'b1, DATA_W'(32'h50 + i), TAG_W'(i), 1'b0, 1'b0);
    cyc(1'b1, DATA_W'(32'h77), TAG_W'(7), 1'b0, 1'b1);
    data_from_B_valid = 1'b0;
    flush             = 1'b0;
    check("flush_level", 64'(level), 64'(0));
    check("flush_valid", 64'(data_to_B_valid), 64'(0));
    idle();

`ifdef MODULE_A_XCHG_CHECKSUM_EN
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b1, DATA_W'(32'h0F), '0, 1'b0, 1'b0);
    cyc(1'b1, DATA_W'(32'hF0), '0, 1'b0, 1'b0);
    cyc(1'b1, DATA_W'(32'hFF), '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("csum_xor", 64'(checksum), 64'(0));
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check("csum_flush", 64'(checksum), 64'(0));
    cyc(1'b1, DATA_W'(32'h12), '0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("csum_single", 64'(checksum), 64'(32'h12));
`endif

    rand_cycles(1500, 1);

    // Asynchronous reset mid-burst, checked before the next clock edge.
    for (int i = 0; i < 6; i++) cyc(1'b1, DATA_W'($urandom), TAG_W'($urandom), 1'b0, 1'b0);
    cyc(1'b1, DATA_W'($urandom), TAG_W'($urandom), 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    data_from_B_valid = 1'b0;
    data_to_B_ready   = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    rand_cycles(800, 2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
